// File: rtl/satd_seq_ctrl.sv
// satd_seq_ctrl: sequencer in front of the SATD datapath.
// One request covers 1..MAX_BLK 8x8 sub-blocks. Each sub-block gets a start
// pulse plus index. The per-sub-block SATD values are summed into one
// saturating cost, which is returned on a valid/ready result port.
//
// Optional feature macro: SATD_SEQ_TIMEOUT_EN
//   defined   : WAIT gives up after ITERATIONS+TO_SLACK silent cycles and
//               returns the partial cost with res_err=1.
//   undefined : no timer; WAIT waits indefinitely; res_err is constant 0.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both 1. The request side (req_valid/req_ready) and the result side
// (res_valid/res_ready) follow this rule. res_valid and res_cost stay stable
// until the transfer. dp_start/dp_done are single-cycle pulses, not handshakes.
module satd_seq_ctrl #(
    parameter int WIDTH      = 8,
    parameter int ITERATIONS = 15,
    parameter int MAX_BLK    = 4,
    parameter int IDX_W      = 2,
    parameter int SATD_W     = 16,
    parameter int ACC_W      = 18,
    parameter int TO_SLACK   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [IDX_W:0]    req_nblk,
    output logic              dp_start,
    output logic [IDX_W-1:0]  dp_idx,
    input  logic              dp_done,
    input  logic [SATD_W-1:0] dp_satd,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_cost,
    output logic              res_err
);

    // Reject configurations the counters and adder below cannot represent.
    if ((WIDTH < 1) || (ITERATIONS < 1) || (TO_SLACK < 0) || (MAX_BLK < 1) ||
        (MAX_BLK > (1 << IDX_W)) || (SATD_W > ACC_W)) begin : g_cfg_check
        $error("satd_seq_ctrl: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [IDX_W:0] MAX_N    = (IDX_W+1)'(MAX_BLK);
    localparam logic [IDX_W:0] NBLK_ONE = (IDX_W+1)'(1);

    state_t              state_q, state_d;
    logic [IDX_W:0]      nblk_q, nblk_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ACC_W-1:0]    acc_q, acc_d;

    logic [ACC_W:0]      sum_ext;
    logic [ACC_W-1:0]    acc_sat;
    logic                last_blk;

`ifdef SATD_SEQ_TIMEOUT_EN
    localparam int TO_LIMIT = ITERATIONS + TO_SLACK;
    localparam int TMR_W    = $clog2(TO_LIMIT + 1);

    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                err_q, err_d;
`endif

    // Saturating accumulate: one extra carry bit detects overflow.
    always_comb begin
        sum_ext  = {1'b0, acc_q} + (ACC_W+1)'(dp_satd);
        acc_sat  = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
        last_blk = ({1'b0, idx_q} == (nblk_q - NBLK_ONE));
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            nblk_q  <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
`ifdef SATD_SEQ_TIMEOUT_EN
            timer_q <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            nblk_q  <= nblk_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
`ifdef SATD_SEQ_TIMEOUT_EN
            timer_q <= timer_d;
            err_q   <= err_d;
`endif
        end
    end

    // Next-state logic; every register holds unless a state says otherwise.
    always_comb begin
        state_d = state_q;
        nblk_d  = nblk_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
`ifdef SATD_SEQ_TIMEOUT_EN
        timer_d = timer_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    nblk_d  = (req_nblk > MAX_N) ? MAX_N : req_nblk;
                    idx_d   = '0;
                    acc_d   = '0;
`ifdef SATD_SEQ_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    // An empty request goes straight to the result with cost 0.
                    state_d = (req_nblk == '0) ? S_OUT : S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef SATD_SEQ_TIMEOUT_EN
                timer_d = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dp_done) begin
                    acc_d = acc_sat;
                    if (last_blk) begin
                        state_d = S_OUT;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end else begin
`ifdef SATD_SEQ_TIMEOUT_EN
                    // The cycle that would bring the timer to the limit ends
                    // the wait, so WAIT lasts exactly TO_LIMIT silent cycles.
                    if (timer_q == TMR_W'(TO_LIMIT - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_OUT;
                    end else if (timer_q != {TMR_W{1'b1}}) begin
                        timer_d = timer_q + 1'b1;
                    end
`endif
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        req_ready = (state_q == S_IDLE);
        dp_start  = (state_q == S_ISSUE);
        dp_idx    = idx_q;
        res_valid = (state_q == S_OUT);
        res_cost  = acc_q;
`ifdef SATD_SEQ_TIMEOUT_EN
        res_err   = err_q;
`else
        res_err   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_satd_seq_ctrl.sv
// Testbench for satd_seq_ctrl. Two instances share all inputs: the default
// ACC_W=18 build and an ACC_W=16 build that exercises cost saturation.
// A stub process plays the SATD datapath with a programmable latency.
module tb_satd_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_nblk = '0;
    logic        dp_done = 1'b0;
    logic [15:0] dp_satd = '0;
    logic        res_ready = 1'b0;

    logic        req_ready, dp_start, res_valid, res_err;
    logic [1:0]  dp_idx;
    logic [17:0] res_cost;

    logic        b_req_ready, b_dp_start, b_res_valid, b_res_err;
    logic [1:0]  b_dp_idx;
    logic [15:0] b_res_cost;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    satd_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_nblk(req_nblk),
        .dp_start(dp_start), .dp_idx(dp_idx), .dp_done(dp_done), .dp_satd(dp_satd),
        .res_valid(res_valid), .res_ready(res_ready), .res_cost(res_cost), .res_err(res_err)
    );

    satd_seq_ctrl #(.ACC_W(16)) dut16 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(b_req_ready), .req_nblk(req_nblk),
        .dp_start(b_dp_start), .dp_idx(b_dp_idx), .dp_done(dp_done), .dp_satd(dp_satd),
        .res_valid(b_res_valid), .res_ready(res_ready), .res_cost(b_res_cost), .res_err(b_res_err)
    );

    // ---------------- SATD stub ----------------
    // Each dp_start consumes one value from stub_vals; the answer is pulsed
    // stub_lat cycles after the start cycle. Empty stub_vals = silent datapath.
    int          stub_lat = 1;
    logic [15:0] stub_vals[$];
    int          pend_cyc[$];
    logic [15:0] pend_val[$];
    int          tcyc = 0;

    always @(posedge clk) begin
        #1;
        tcyc++;
        dp_done = 1'b0;
        if (pend_cyc.size() > 0 && pend_cyc[0] == tcyc) begin
            dp_done = 1'b1;
            dp_satd = pend_val.pop_front();
            void'(pend_cyc.pop_front());
        end
        if (dp_start && stub_vals.size() > 0) begin
            pend_cyc.push_back(tcyc + stub_lat);
            pend_val.push_back(stub_vals.pop_front());
        end
    end

    // ---------------- scoreboard ----------------
    logic [17:0] exp_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Cost of a request = sum of the first min(nblk,MAX_BLK) answers, capped
    // at the accumulator's full-scale value.
    function automatic longint model_cost(input int nblk, input logic [63:0] vals, input int accw);
        longint sum = 0;
        int n = (nblk > 4) ? 4 : nblk;
        for (int i = 0; i < n; i++) sum += longint'(vals[i*16 +: 16]);
        if (sum > (longint'(1) << accw) - 1) sum = (longint'(1) << accw) - 1;
        return sum;
    endfunction

    function automatic int model_cycle(input int nblk, input int lat);
        int n = (nblk > 4) ? 4 : nblk;
        return (n == 0) ? 1 : n * (lat + 1) + 1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE; returns positioned in cycle 1 after accept.
    task automatic accept(input int nblk);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_nblk  = 3'(nblk);
        step();
        req_valid = 1'b0;
    endtask

    // Watch cycles 1..budget for dp_start pulses and the rise of res_valid.
    task automatic collect(input int budget, output int rise, output int nstart,
                           output int last_start);
        int cyc = 1;
        rise = -1; nstart = 0; last_start = -1;
        while (cyc <= budget) begin
            if (res_valid) begin
                rise = cyc;
                break;
            end
            if (dp_start) begin
                check("dp_idx", dp_idx, nstart);
                nstart++;
                last_start = cyc;
            end
            step();
            cyc++;
        end
    endtask

    task automatic run_req(input string name, input int nblk, input int lat,
                           input logic [63:0] vals, input int hold,
                           input longint exp18, input longint exp16, input int exp_cyc);
        int rise, nstart, last_start;
        logic [17:0] exp_cost;
        stub_lat = lat;
        stub_vals.delete();
        for (int i = 0; i < 4; i++) stub_vals.push_back(vals[i*16 +: 16]);
        exp_q.push_back(18'(exp18));
        accept(nblk);
        collect(400, rise, nstart, last_start);
        exp_cost = exp_q.pop_front();
        check({name, "_res_valid_cycle"}, rise, exp_cyc);
        check({name, "_dp_start_count"}, nstart, (nblk > 4) ? 4 : nblk);
        check({name, "_res_cost"}, res_cost, exp_cost);
        check({name, "_res_cost16"}, b_res_cost, exp16);
        check({name, "_res_err"}, res_err, 0);
        // Stall the result; a competing request must not be taken.
        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0;
            req_valid = 1'b1;
            req_nblk  = 3'd1;
            step();
            check({name, "_hold_valid"}, res_valid, 1);
            check({name, "_hold_cost"}, res_cost, exp_cost);
            check({name, "_hold_req_ready"}, req_ready, 0);
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check({name, "_post_hs_valid"}, res_valid, 0);
        check({name, "_post_hs_req_ready"}, req_ready, 1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_req_ready"}, req_ready, 1);
        check({name, "_dp_start"}, dp_start, 0);
        check({name, "_dp_idx"}, dp_idx, 0);
        check({name, "_res_valid"}, res_valid, 0);
        check({name, "_res_cost"}, res_cost, 0);
        check({name, "_res_err"}, res_err, 0);
    endtask

    typedef struct {
        int          nblk;
        int          lat;
        logic [63:0] vals;
        int          hold;
        int          exp18;
        int          exp16;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int rise, nstart, last_start;
        int bad, saw_done;

        // Directed table: {nblk, latency, answers v3..v0, hold, cost18, cost16, rise cycle}
        vecs[0] = '{4, 15, 64'h0190_012C_00C8_0064, 10, 1000, 1000, 65};
        vecs[1] = '{4, 3, 64'hFFFF_FFFF_FFFF_FFFF, 0, 262140, 65535, 17};
        vecs[2] = '{0, 5, 64'h0001_0002_0003_0004, 0, 0, 0, 1};
        vecs[3] = '{7, 2, 64'h0028_001E_0014_000A, 2, 100, 100, 13};
        vecs[4] = '{1, 1, 64'h0000_0000_0000_1234, 0, 4660, 4660, 3};
        vecs[5] = '{2, 20, 64'h0000_0000_9C40_9C40, 1, 80000, 65535, 43};
        vecs[6] = '{3, 1, 64'h0000_0003_0002_0001, 0, 6, 6, 7};
        vecs[7] = '{5, 4, 64'h8000_8000_0000_7FFF, 0, 98303, 65535, 21};

        // Reset values while reset is held.
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        for (int v = 0; v < 8; v++) begin
            run_req($sformatf("vec%0d", v), vecs[v].nblk, vecs[v].lat, vecs[v].vals,
                    vecs[v].hold, vecs[v].exp18, vecs[v].exp16, vecs[v].exp_cyc);
        end

        // Datapath answers the first sub-block, then goes silent.
        stub_lat = 4;
        stub_vals.delete();
        stub_vals.push_back(16'd50);
        accept(2);
`ifdef SATD_SEQ_TIMEOUT_EN
        collect(200, rise, nstart, last_start);
        check("to_second_start_cycle", last_start, 6);
        check("to_res_valid_cycle", rise, last_start + 24);
        check("to_res_err", res_err, 1);
        check("to_res_cost", res_cost, 50);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("to_post_hs_req_ready", req_ready, 1);
`else
        collect(120, rise, nstart, last_start);
        check("noto_no_result", rise, -1);
        check("noto_start_count", nstart, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
`endif

        // Reset during WAIT of sub-block 2; its answer arrives late.
        stub_lat = 10;
        stub_vals.delete();
        for (int i = 5; i <= 8; i++) stub_vals.push_back(16'(i));
        accept(4);
        for (int c = 0; c < 100 && !(dp_start && dp_idx == 2'd2); c++) step();
        check("rst_reach_blk2", dp_start && dp_idx == 2'd2, 1);
        step();
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        step();
        rst = 1'b0;
        stub_vals.delete();
        bad = 0;
        saw_done = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (dp_done) saw_done = 1;
            if (res_valid || dp_start || !req_ready || res_cost != 0) bad = 1;
        end
        check("midrst_late_done_seen", saw_done, 1);
        check("midrst_outputs_stay_reset", bad, 0);

        // Randomized requests against the reference model.
        for (int r = 0; r < 16; r++) begin
            int nb, lt, hd;
            logic [63:0] vv;
            nb = $urandom_range(0, 7);
            lt = $urandom_range(1, 12);
            hd = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) begin
                vv[i*16 +: 16] = (r % 3 == 0) ? 16'($urandom_range(60000, 65535))
                                              : 16'($urandom_range(0, 65535));
            end
            run_req($sformatf("rnd%0d", r), nb, lt, vv, hd,
                    model_cost(nb, vv, 18), model_cost(nb, vv, 16), model_cycle(nb, lt));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
